// File: rtl/pic_pkg.sv
// Shared definitions for the ICW/OCW command sequencer: FSM states,
// OCW2 command codes and bit positions used when decoding written bytes.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } pic_state_t;

  // OCW2 D7:5 = {R, SL, EOI}
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIORITY = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int CMD_D4    = 4;
  localparam int OCW_D3    = 3;
  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

endpackage

// File: rtl/pic_wr_edge_detect.sv
// Rising-edge detector on the bus write level, built on a registered
// history bit so a level held for many cycles yields a single pulse.
module pic_wr_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic write_flag,
  output logic write_edge
);

  logic prev_reg;

  always_ff @(posedge clk) begin
    if (reset) prev_reg <= 1'b0;
    else       prev_reg <= write_flag;
  end

  assign write_edge = write_flag & ~prev_reg;

endmodule

// File: rtl/icw_ocw_sequencer.sv
// ICW1..ICW4 initialisation sequencer and OCW1..OCW3 decoder.
// Optional special mask mode handling is enabled by SPECIAL_MASK_MODE_EN.
module icw_ocw_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] IMR_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write_flag,
  input  logic       Ao,
  input  logic [7:0] data_in,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic [4:0] vector_base,
  output logic [7:0] icw3_reg,
  output logic       aeoi,
  output logic       upm,
  output logic [7:0] imr,
  output logic       eoi_valid,
  output logic [2:0] eoi_cmd,
  output logic [2:0] eoi_level,
  output logic       read_isr_sel,
  output logic       poll_req,
  output logic       smm
);

  pic_state_t state_reg;
  logic       ic4_reg;
  logic       write_edge;
  logic       is_icw1;

  pic_wr_edge_detect u_edge (
    .clk        (clk),
    .reset      (reset),
    .write_flag (write_flag),
    .write_edge (write_edge)
  );

  // ICW1 restarts initialisation from any state, including READY
  assign is_icw1 = ~Ao & data_in[CMD_D4];

`ifdef SPECIAL_MASK_MODE_EN
  logic smm_reg;
  assign smm = smm_reg;
`else
  assign smm = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ic4_reg      <= 1'b0;
      init_done    <= 1'b0;
      ltim         <= 1'b0;
      sngl         <= 1'b0;
      vector_base  <= 5'd0;
      icw3_reg     <= 8'h00;
      aeoi         <= 1'b0;
      upm          <= 1'b0;
      imr          <= IMR_INIT;
      eoi_valid    <= 1'b0;
      eoi_cmd      <= 3'd0;
      eoi_level    <= 3'd0;
      read_isr_sel <= 1'b0;
      poll_req     <= 1'b0;
`ifdef SPECIAL_MASK_MODE_EN
      smm_reg      <= 1'b0;
`endif
    end else begin
      eoi_valid <= 1'b0;
      poll_req  <= 1'b0;
      if (write_edge) begin
        if (is_icw1) begin
          ltim         <= data_in[ICW1_LTIM];
          sngl         <= data_in[ICW1_SNGL];
          ic4_reg      <= data_in[ICW1_IC4];
          imr          <= IMR_INIT;
          aeoi         <= 1'b0;
          upm          <= 1'b0;
          read_isr_sel <= 1'b0;
          init_done    <= 1'b0;
`ifdef SPECIAL_MASK_MODE_EN
          smm_reg      <= 1'b0;
`endif
          state_reg    <= WAIT_ICW2;
        end else begin
          case (state_reg)
            WAIT_ICW2: if (Ao) begin
              vector_base <= data_in[7:3];
              if (!sngl) begin
                state_reg <= WAIT_ICW3;
              end else if (ic4_reg) begin
                state_reg <= WAIT_ICW4;
              end else begin
                state_reg <= READY;
                init_done <= 1'b1;
              end
            end
            WAIT_ICW3: if (Ao) begin
              icw3_reg <= data_in;
              if (ic4_reg) begin
                state_reg <= WAIT_ICW4;
              end else begin
                state_reg <= READY;
                init_done <= 1'b1;
              end
            end
            WAIT_ICW4: if (Ao) begin
              upm       <= data_in[0];
              aeoi      <= data_in[1];
              state_reg <= READY;
              init_done <= 1'b1;
            end
            READY: begin
              if (Ao) begin
                imr <= data_in;
              end else if (!data_in[OCW_D3]) begin
                eoi_valid <= 1'b1;
                eoi_cmd   <= data_in[7:5];
                eoi_level <= data_in[2:0];
              end else begin
                if (data_in[OCW3_RR]) read_isr_sel <= data_in[OCW3_RIS];
                if (data_in[OCW3_P])  poll_req     <= 1'b1;
`ifdef SPECIAL_MASK_MODE_EN
                if (data_in[OCW3_ESMM]) smm_reg <= data_in[OCW3_SMM];
`endif
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Directed testbench for icw_ocw_sequencer; honours SPECIAL_MASK_MODE_EN
// when choosing the expected smm value.
module tb_icw_ocw_sequencer;

  localparam logic [7:0] TB_IMR_INIT = 8'h5A;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_flag = 1'b0;
  logic       Ao = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       init_done, ltim, sngl, aeoi, upm, eoi_valid, read_isr_sel, poll_req, smm;
  logic [4:0] vector_base;
  logic [7:0] icw3_reg, imr;
  logic [2:0] eoi_cmd, eoi_level;

  int tests = 0;
  int failed = 0;

  logic       snap_eoi_valid, snap_poll, after_eoi_valid, after_poll;
  logic [2:0] snap_eoi_cmd, snap_eoi_level;

  icw_ocw_sequencer #(.IMR_INIT(TB_IMR_INIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .write_flag   (write_flag),
    .Ao           (Ao),
    .data_in      (data_in),
    .init_done    (init_done),
    .ltim         (ltim),
    .sngl         (sngl),
    .vector_base  (vector_base),
    .icw3_reg     (icw3_reg),
    .aeoi         (aeoi),
    .upm          (upm),
    .imr          (imr),
    .eoi_valid    (eoi_valid),
    .eoi_cmd      (eoi_cmd),
    .eoi_level    (eoi_level),
    .read_isr_sel (read_isr_sel),
    .poll_req     (poll_req),
    .smm          (smm)
  );

  always #5 clk = ~clk;

  // One write transaction: level high for one cycle, strobes sampled in the
  // cycle after the edge and again one cycle later.
  task automatic wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    Ao = a; data_in = d; write_flag = 1'b1;
    @(posedge clk); #1;
    snap_eoi_valid = eoi_valid; snap_poll = poll_req;
    snap_eoi_cmd = eoi_cmd; snap_eoi_level = eoi_level;
    @(negedge clk);
    write_flag = 1'b0;
    @(posedge clk); #1;
    after_eoi_valid = eoi_valid; after_poll = poll_req;
    $display("[TB] wr Ao=%0d data=%h imr=%h init_done=%0d", a, d, imr, init_done);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; write_flag = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset");
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (imr !== TB_IMR_INIT) begin failed++; $display("FAIL reset_imr got %h want %h", imr, TB_IMR_INIT); end
    tests++; if ({init_done, ltim, sngl, aeoi, upm, read_isr_sel, eoi_valid, poll_req, smm} !== 9'b0) begin
      failed++; $display("FAIL reset_flags got %b want 0", {init_done, ltim, sngl, aeoi, upm, read_isr_sel, eoi_valid, poll_req, smm}); end
    tests++; if ({vector_base, icw3_reg, eoi_cmd, eoi_level} !== 19'd0) begin
      failed++; $display("FAIL reset_fields got %h want 0", {vector_base, icw3_reg, eoi_cmd, eoi_level}); end
  endtask

  task automatic test_init_single_ic4();
    wr(1'b0, 8'h13);
    tests++; if ({ltim, sngl, init_done} !== 3'b010) begin failed++; $display("FAIL icw1_latch got %b want 010", {ltim, sngl, init_done}); end
    wr(1'b1, 8'h40);
    tests++; if (vector_base !== 5'h08) begin failed++; $display("FAIL icw2_vec got %h want 08", vector_base); end
    tests++; if (init_done !== 1'b0) begin failed++; $display("FAIL icw2_not_done got %b want 0", init_done); end
    // Ao=0/D4=0 while waiting for ICW4 must be dropped
    wr(1'b0, 8'h0B);
    tests++; if (read_isr_sel !== 1'b0) begin failed++; $display("FAIL nonready_ocw3 got %b want 0", read_isr_sel); end
    wr(1'b1, 8'h03);
    tests++; if ({aeoi, upm, init_done} !== 3'b111) begin failed++; $display("FAIL icw4 got %b want 111", {aeoi, upm, init_done}); end
    tests++; if (icw3_reg !== 8'h00) begin failed++; $display("FAIL icw3_skipped got %h want 00", icw3_reg); end
  endtask

  task automatic test_init_cascade();
    wr(1'b1, 8'h77);
    wr(1'b0, 8'h10);
    tests++; if ({aeoi, upm, init_done} !== 3'b000) begin failed++; $display("FAIL icw1_clear got %b want 000", {aeoi, upm, init_done}); end
    tests++; if (imr !== TB_IMR_INIT) begin failed++; $display("FAIL icw1_imr got %h want %h", imr, TB_IMR_INIT); end
    wr(1'b1, 8'h20);
    tests++; if ({vector_base, init_done} !== {5'h04, 1'b0}) begin failed++; $display("FAIL icw2_casc got %h want 08", {vector_base, init_done}); end
    wr(1'b1, 8'h04);
    tests++; if ({icw3_reg, aeoi, init_done} !== {8'h04, 1'b0, 1'b1}) begin
      failed++; $display("FAIL icw3_ready got %h want 011", {icw3_reg, aeoi, init_done}); end
  endtask

  task automatic test_ocw12();
    wr(1'b1, 8'hA5);
    tests++; if (imr !== 8'hA5) begin failed++; $display("FAIL ocw1_imr got %h want a5", imr); end
    wr(1'b0, 8'h63);
    tests++; if ({snap_eoi_valid, snap_eoi_cmd, snap_eoi_level} !== {1'b1, 3'b011, 3'd3}) begin
      failed++; $display("FAIL ocw2_strobe got %b want 1011011", {snap_eoi_valid, snap_eoi_cmd, snap_eoi_level}); end
    tests++; if (after_eoi_valid !== 1'b0) begin failed++; $display("FAIL ocw2_one_cycle got %b want 0", after_eoi_valid); end
  endtask

  task automatic test_ocw3();
    int polls;
    wr(1'b0, 8'h0B);
    tests++; if ({read_isr_sel, snap_poll} !== 2'b10) begin failed++; $display("FAIL ocw3_ris got %b want 10", {read_isr_sel, snap_poll}); end
    wr(1'b0, 8'h0C);
    tests++; if ({snap_poll, after_poll, read_isr_sel} !== 3'b101) begin
      failed++; $display("FAIL ocw3_poll got %b want 101", {snap_poll, after_poll, read_isr_sel}); end
    polls = 0;
    @(negedge clk);
    Ao = 1'b0; data_in = 8'h0C; write_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (poll_req) polls++;
    end
    @(negedge clk);
    write_flag = 1'b0;
    @(posedge clk); #1;
    if (poll_req) polls++;
    $display("[TB] held write 5 cycles data=0c polls=%0d", polls);
    tests++; if (polls !== 1) begin failed++; $display("FAIL held_write got %0d want 1", polls); end
  endtask

  task automatic test_smm();
    logic exp_smm;
`ifdef SPECIAL_MASK_MODE_EN
    exp_smm = 1'b1;
`else
    exp_smm = 1'b0;
`endif
    wr(1'b0, 8'h68);
    tests++; if (smm !== exp_smm) begin failed++; $display("FAIL ocw3_smm got %b want %b", smm, exp_smm); end
    tests++; if (read_isr_sel !== 1'b1) begin failed++; $display("FAIL smm_ris_kept got %b want 1", read_isr_sel); end
  endtask

  task automatic test_reset_mid_sequence();
    wr(1'b0, 8'h10);
    wr(1'b1, 8'h20);
    do_reset();
    wr(1'b1, 8'hFF);
    tests++; if ({imr, init_done, vector_base, icw3_reg} !== {TB_IMR_INIT, 1'b0, 5'd0, 8'h00}) begin
      failed++; $display("FAIL mid_reset got %h want %h", {imr, init_done, vector_base, icw3_reg}, {TB_IMR_INIT, 1'b0, 5'd0, 8'h00}); end
  endtask

  task automatic test_reset_vs_write();
    wr(1'b0, 8'h12);
    wr(1'b1, 8'h08);
    tests++; if (init_done !== 1'b1) begin failed++; $display("FAIL quick_init got %b want 1", init_done); end
    @(negedge clk);
    reset = 1'b1; Ao = 1'b1; data_in = 8'h33; write_flag = 1'b1;
    @(posedge clk); #1;
    tests++; if ({imr, init_done} !== {TB_IMR_INIT, 1'b0}) begin
      failed++; $display("FAIL reset_wins got %h want %h", {imr, init_done}, {TB_IMR_INIT, 1'b0}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    write_flag = 1'b0;
    @(posedge clk); #1;
    $display("[TB] reset with coincident write data=33");
    tests++; if (imr !== TB_IMR_INIT) begin failed++; $display("FAIL post_reset_write got %h want %h", imr, TB_IMR_INIT); end
  endtask

  initial begin
    test_reset();
    test_init_single_ic4();
    test_init_cascade();
    test_ocw12();
    test_ocw3();
    test_smm();
    test_reset_mid_sequence();
    test_reset_vs_write();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/icw_ocw_sequencer.md
ICW_OCW_SEQUENCER -- requirements
Module: icw_ocw_sequencer

Interface
REQ-001 SHALL have parameter IMR_INIT, default 8'h00, value loaded into imr on ICW1 and on reset.
REQ-002 SHALL have ports in this order:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- write_flag  in  1  write request level from the bus read/write logic.
- Ao  in  1  address bit qualifying the written byte.
- data_in  in  8  written byte.
- init_done  out  1  high once the ICW sequence is complete.
- ltim  out  1  ICW1 D3, level-triggered mode.
- sngl  out  1  ICW1 D1, single (no cascade).
- vector_base  out  5  ICW2 D7:3.
- icw3_reg  out  8  ICW3 byte, slave mask or ID.
- aeoi  out  1  ICW4 D1, auto end-of-interrupt.
- upm  out  1  ICW4 D0, 8086 mode.
- imr  out  8  OCW1 interrupt mask.
- eoi_valid  out  1  one-cycle OCW2 strobe.
- eoi_cmd  out  3  OCW2 D7:5 (R, SL, EOI).
- eoi_level  out  3  OCW2 D2:0.
- read_isr_sel  out  1  OCW3 RIS: 1 selects ISR, 0 selects IRR.
- poll_req  out  1  one-cycle OCW3 poll strobe.
- smm  out  1  special mask mode active.

Function
REQ-003 SHALL detect the rising edge of write_flag (registered previous value); one command per edge, with Ao and data_in sampled in that same cycle.
REQ-004 SHALL implement FSM states IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4 and READY.
REQ-005 Any write with Ao=0 and D4=1 is ICW1, in any state:
- latch ltim, sngl and IC4 (D0).
- set imr to IMR_INIT, aeoi and upm to 0, read_isr_sel to 0, smm to 0, init_done to 0.
- go to WAIT_ICW2.
REQ-006 WAIT_ICW2, write with Ao=1: vector_base is set to D7:3; next state is WAIT_ICW3 if sngl=0, else WAIT_ICW4 if IC4=1, else READY.
REQ-007 WAIT_ICW3, write with Ao=1: icw3_reg is set to the byte; next state is WAIT_ICW4 if IC4=1, else READY.
REQ-008 WAIT_ICW4, write with Ao=1: upm is set to D0 and aeoi to D1; next state is READY.
REQ-009 Whenever IC4=0 on the ICW1 just accepted, aeoi and upm SHALL stay 0.
REQ-010 init_done SHALL rise in the cycle after the write that enters READY and stay high until the next ICW1 or reset.
REQ-011 READY, Ao=1: OCW1; imr is set to the byte.
REQ-012 READY, Ao=0, D4=0, D3=0: OCW2; for exactly one cycle, eoi_valid=1, eoi_cmd=D7:5 and eoi_level=D2:0.
REQ-013 READY, Ao=0, D4=0, D3=1: OCW3.
- If D1=1, read_isr_sel is set to D0; if D1=0, read_isr_sel is unchanged.
- If D2=1, poll_req=1 for exactly one cycle.
REQ-014 Writes with Ao=0 and D4=0 in any non-READY state SHALL be ignored, with no state or output change.
REQ-015 All register outputs SHALL update on the clock edge after the write edge is detected; strobe latency is 1 cycle.
REQ-016 A write_flag held high for N cycles SHALL produce exactly one command.
REQ-017 If a write edge and reset coincide, reset SHALL win.

Reset
REQ-018 On reset=1 at a clk edge, the block SHALL enter IDLE with these values:
- imr=IMR_INIT.
- All other outputs and internal registers 0, including the write_flag history.
REQ-019 Reset mid-sequence, in any WAIT_* state, SHALL discard the partial initialisation.

Configuration
REQ-020 With macro SPECIAL_MASK_MODE_EN defined: on OCW3, if D6 (ESMM) =1, smm is set to D5 (SMM); otherwise smm is unchanged.
REQ-021 Without SPECIAL_MASK_MODE_EN: smm SHALL be constant 0, and OCW3 D6:5 SHALL be ignored.

Structure
REQ-022 Shared package pic_pkg SHALL hold:
- the FSM state enum.
- OCW2 command codes (non-specific EOI, specific EOI, rotate variants).
- bit-position constants for ICW1/OCW2/OCW3 decoding.
REQ-023 One sub-module, pic_wr_edge_detect, SHALL provide the registered write_flag rising-edge pulse.

Verification
REQ-024 Reset, then ICW1=8'h13 (Ao=0), then ICW2=8'h40, then ICW4=8'h03 -> vector_base=5'h08, ICW3 skipped, aeoi=1, upm=1, init_done=1.
REQ-025 ICW1=8'h10, ICW2=8'h20, ICW3=8'h04 -> READY after ICW3, icw3_reg=8'h04, aeoi=0.
REQ-026 In READY: OCW1 8'hA5 -> imr=8'hA5; then OCW2 8'h63 -> one-cycle eoi_valid with eoi_cmd=3'b011 and eoi_level=3'd3.
REQ-027 In READY: OCW3 8'h0B -> read_isr_sel=1; then OCW3 8'h0C -> one-cycle poll_req, read_isr_sel stays 1; write_flag held high 5 cycles -> single command.
REQ-028 Reset asserted in WAIT_ICW3 -> IDLE; a following OCW1 byte is ignored and init_done stays 0.
REQ-029 With SPECIAL_MASK_MODE_EN: OCW3 8'h68 -> smm=1. Without the macro, the same write -> smm=0.
